// File: rtl/i2c_fifo_buffer.sv
// Dual show-ahead byte FIFO between the APB slave (TX push / RX pop) and the
// I2C master core (TX pop / RX push). Both FIFOs share PCLK and the clr flush.
module i2c_fifo_buffer_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [7:0]    wdata_i,
  input  logic          rd_i,
  output logic [7:0]    rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          ovf_o
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        push_acc, pop_acc;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign ovf_o   = ovf_q;

  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  assign pop_acc  = rd_i && !empty_o;
  assign push_acc = wr_i && (!full_o || pop_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_acc)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (wr_i && !push_acc) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      if (push_acc && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

module i2c_fifo_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          PCLK,
  input  logic          PRESETn,
  input  logic          clr,
  input  logic          tx_wr,
  input  logic [7:0]    tx_wdata,
  input  logic          tx_rd,
  output logic [7:0]    tx_rdata,
  output logic          tx_full,
  output logic          tx_empty,
  output logic [AW:0]   tx_level,
  output logic          tx_ovf,
  input  logic          rx_wr,
  input  logic [7:0]    rx_wdata,
  input  logic          rx_rd,
  output logic [7:0]    rx_rdata,
  output logic          rx_full,
  output logic          rx_empty,
  output logic [AW:0]   rx_level,
  output logic          rx_ovf,
  output logic          rx_udf
);

  logic rx_udf_q, rx_udf_d;

  i2c_fifo_buffer_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk_i   (PCLK),
    .rst_n_i (PRESETn),
    .clr_i   (clr),
    .wr_i    (tx_wr),
    .wdata_i (tx_wdata),
    .rd_i    (tx_rd),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .level_o (tx_level),
    .ovf_o   (tx_ovf)
  );

  i2c_fifo_buffer_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk_i   (PCLK),
    .rst_n_i (PRESETn),
    .clr_i   (clr),
    .wr_i    (rx_wr),
    .wdata_i (rx_wdata),
    .rd_i    (rx_rd),
    .rdata_o (rx_rdata),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .level_o (rx_level),
    .ovf_o   (rx_ovf)
  );

  // TX underflow is not tracked: the I2C core never pops without checking tx_empty.
  always_comb begin
    rx_udf_d = rx_udf_q;
    if (clr)                    rx_udf_d = 1'b0;
    else if (rx_rd && rx_empty) rx_udf_d = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) rx_udf_q <= 1'b0;
    else          rx_udf_q <= rx_udf_d;
  end

  assign rx_udf = rx_udf_q;

endmodule

// File: tb/tb_i2c_fifo_buffer.sv
// Directed bench for i2c_fifo_buffer: hand-computed expectations checked with
// immediate assertions after each clock step.
module tb_i2c_fifo_buffer;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       clr = 1'b0;
  logic       tx_wr = 1'b0, tx_rd = 1'b0, rx_wr = 1'b0, rx_rd = 1'b0;
  logic [7:0] tx_wdata = 8'h00, rx_wdata = 8'h00;
  logic [7:0] tx_rdata, rx_rdata;
  logic       tx_full, tx_empty, tx_ovf, rx_full, rx_empty, rx_ovf, rx_udf;
  logic [4:0] tx_level, rx_level;

  int checks = 0;
  int errors = 0;

  i2c_fifo_buffer #(.DEPTH(16), .AW(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .clr(clr),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_rd(tx_rd), .tx_rdata(tx_rdata),
    .tx_full(tx_full), .tx_empty(tx_empty), .tx_level(tx_level), .tx_ovf(tx_ovf),
    .rx_wr(rx_wr), .rx_wdata(rx_wdata), .rx_rd(rx_rd), .rx_rdata(rx_rdata),
    .rx_full(rx_full), .rx_empty(rx_empty), .rx_level(rx_level), .rx_ovf(rx_ovf),
    .rx_udf(rx_udf)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_tx_empty"}, 16'(tx_empty), 16'h1);
    chk({tag, "_tx_full"},  16'(tx_full),  16'h0);
    chk({tag, "_tx_level"}, 16'(tx_level), 16'h0);
    chk({tag, "_tx_rdata"}, 16'(tx_rdata), 16'h0);
    chk({tag, "_tx_ovf"},   16'(tx_ovf),   16'h0);
    chk({tag, "_rx_empty"}, 16'(rx_empty), 16'h1);
    chk({tag, "_rx_full"},  16'(rx_full),  16'h0);
    chk({tag, "_rx_level"}, 16'(rx_level), 16'h0);
    chk({tag, "_rx_rdata"}, 16'(rx_rdata), 16'h0);
    chk({tag, "_rx_ovf"},   16'(rx_ovf),   16'h0);
    chk({tag, "_rx_udf"},   16'(rx_udf),   16'h0);
  endtask

  initial begin
    #12;
    chk_reset_state("reset");
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    // single TX push then pop
    tx_wr = 1'b1; tx_wdata = 8'hA5;
    step();
    tx_wr = 1'b0;
    chk("tx1_rdata", 16'(tx_rdata), 16'hA5);
    chk("tx1_level", 16'(tx_level), 16'd1);
    chk("tx1_empty", 16'(tx_empty), 16'h0);
    tx_rd = 1'b1;
    step();
    tx_rd = 1'b0;
    chk("tx1_empty_after_pop", 16'(tx_empty), 16'h1);
    chk("tx1_level_after_pop", 16'(tx_level), 16'd0);

    // RX fill, overflow, ordered drain
    rx_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_wdata = 8'(i);
      step();
    end
    chk("rx_full", 16'(rx_full), 16'h1);
    chk("rx_level16", 16'(rx_level), 16'd16);
    chk("rx_ovf_before", 16'(rx_ovf), 16'h0);
    rx_wdata = 8'h99;
    step();
    rx_wr = 1'b0;
    chk("rx_ovf_set", 16'(rx_ovf), 16'h1);
    chk("rx_level_after_ovf", 16'(rx_level), 16'd16);
    for (int i = 0; i < 16; i++) begin
      chk("rx_drain_data", 16'(rx_rdata), 16'(i));
      rx_rd = 1'b1;
      step();
      rx_rd = 1'b0;
    end
    chk("rx_drained_empty", 16'(rx_empty), 16'h1);
    chk("rx_udf_clean", 16'(rx_udf), 16'h0);
    chk("rx_ovf_sticky", 16'(rx_ovf), 16'h1);

    // TX full with simultaneous push/pop
    tx_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_wdata = 8'(i);
      step();
    end
    chk("tx_full", 16'(tx_full), 16'h1);
    tx_rd = 1'b1; tx_wdata = 8'hEE;
    step();
    tx_wr = 1'b0; tx_rd = 1'b0;
    chk("tx_full_stays", 16'(tx_full), 16'h1);
    chk("tx_full_level", 16'(tx_level), 16'd16);
    chk("tx_full_ovf", 16'(tx_ovf), 16'h0);
    for (int i = 1; i <= 16; i++) begin
      chk("tx_drain_data", 16'(tx_rdata), (i == 16) ? 16'hEE : 16'(i));
      tx_rd = 1'b1;
      step();
      tx_rd = 1'b0;
    end
    chk("tx_drained_empty", 16'(tx_empty), 16'h1);

    // RX empty with simultaneous push/pop
    rx_wr = 1'b1; rx_rd = 1'b1; rx_wdata = 8'h3C;
    step();
    rx_wr = 1'b0; rx_rd = 1'b0;
    chk("rx_pp_level", 16'(rx_level), 16'd1);
    chk("rx_pp_udf", 16'(rx_udf), 16'h1);
    chk("rx_pp_rdata", 16'(rx_rdata), 16'h3C);
    rx_rd = 1'b1;
    step();
    rx_rd = 1'b0;
    chk("rx_pp_empty", 16'(rx_empty), 16'h1);

    // pointer wrap at level 15
    tx_wr = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tx_wdata = 8'(i);
      step();
    end
    tx_rd = 1'b1;
    for (int j = 0; j < 48; j++) begin
      chk("wrap_head", 16'(tx_rdata), 16'(j));
      tx_wdata = 8'(15 + j);
      step();
      chk("wrap_level", 16'(tx_level), 16'd15);
    end
    tx_wr = 1'b0;
    for (int j = 48; j < 63; j++) begin
      chk("wrap_drain", 16'(tx_rdata), 16'(j));
      step();
    end
    tx_rd = 1'b0;
    chk("wrap_empty", 16'(tx_empty), 16'h1);

    // level 5 on both, then clr with a concurrent push
    tx_wr = 1'b1; rx_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_wdata = 8'(8'h40 + i); rx_wdata = 8'(8'h50 + i);
      step();
    end
    rx_wr = 1'b0;
    chk("pre_clr_tx_level", 16'(tx_level), 16'd5);
    chk("pre_clr_rx_level", 16'(rx_level), 16'd5);
    chk("pre_clr_rx_udf", 16'(rx_udf), 16'h1);
    clr = 1'b1; tx_wdata = 8'h77;
    step();
    clr = 1'b0; tx_wr = 1'b0;
    chk("clr_tx_empty", 16'(tx_empty), 16'h1);
    chk("clr_tx_level", 16'(tx_level), 16'd0);
    chk("clr_rx_empty", 16'(rx_empty), 16'h1);
    chk("clr_rx_level", 16'(rx_level), 16'd0);
    chk("clr_rx_ovf", 16'(rx_ovf), 16'h0);
    chk("clr_rx_udf", 16'(rx_udf), 16'h0);
    chk("clr_tx_ovf", 16'(tx_ovf), 16'h0);

    // async reset mid-traffic
    tx_wr = 1'b1; rx_wr = 1'b1; tx_wdata = 8'h81; rx_wdata = 8'h82;
    step();
    step();
    chk("pre_rst_tx_level", 16'(tx_level), 16'd2);
    #2;
    PRESETn = 1'b0;
    #1;
    chk_reset_state("async_rst");
    tx_wr = 1'b0; rx_wr = 1'b0;
    step();
    PRESETn = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
